adc_capture_ctrl: RTL and testbench
===================================

Name: adc_capture_ctrl

Overview:
Capture/readback controller that sits directly upstream of the 8192x10 single-port ADC sample RAM, driving its ce/oce/wre/ad/din pins and consuming its dout.
On start, it writes cap_len consecutive valid ADC samples into RAM addresses 0..cap_len-1.
It then streams the stored block out in address order over a valid/ready interface to the OFDM receive path.

Parameters:
DEPTH, 8192, RAM depth in samples (power of two)
ADDR_W, 13, RAM address width, log2(DEPTH)
DATA_W, 10, ADC sample width

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
start  in  1  capture request, sampled only in IDLE
abort  in  1  return to IDLE immediately, any state
cap_len  in  ADDR_W+1  samples per capture, legal 1..DEPTH
adc_data  in  DATA_W  ADC sample
adc_valid  in  1  adc_data valid this cycle
busy  out  1  high in CAPTURE or READ
done  out  1  1-cycle pulse after last sample is read out
rd_data  out  DATA_W  readback sample
rd_valid  out  1  rd_data valid
rd_ready  in  1  consumer accepts rd_data
ram_ce  out  1  RAM clock enable
ram_oce  out  1  RAM output clock enable, tied 1
ram_wre  out  1  RAM write enable
ram_ad  out  ADDR_W  RAM address
ram_din  out  DATA_W  RAM write data
ram_dout  in  DATA_W  RAM read data, valid 1 clk after a read address is presented

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: state IDLE, busy=0, done=0, rd_valid=0, rd_data=0. Internal wr_addr, rd_addr, out_cnt, len and in_flight all clear to 0.
- States:
  - IDLE: ram_ce=0, ram_wre=0.
  - On start=1 with 1<=cap_len<=DEPTH: latch len=cap_len, clear wr_addr, go to CAPTURE.
  - start with cap_len=0 or cap_len>DEPTH: ignored, stay IDLE.
  - start outside IDLE: ignored.
- CAPTURE:
  - Combinational write path: ram_ce=1, ram_wre=adc_valid, ram_ad=wr_addr, ram_din=adc_data.
  - wr_addr increments on each adc_valid.
  - adc_valid with wr_addr==len-1: final write. Next state is READ; clear rd_addr, out_cnt and in_flight.
  - adc_valid=0 cycles are gaps and write nothing.
- READ:
  - ram_wre=0 and ram_ce=1. ram_ad=rd_addr.
  - Issue condition: rd_addr<len, in_flight=0, and (rd_valid=0 or rd_ready=1).
  - On issue: rd_addr increments and in_flight is set for one cycle.
  - The cycle after issue: rd_data<=ram_dout, rd_valid<=1, in_flight<=0.
  - Transfer occurs when rd_valid & rd_ready. On a transfer with no new data arriving, rd_valid<=0.
  - rd_data and rd_valid hold stable while rd_valid=1 and rd_ready=0.
  - Throughput is at most 1 sample per 2 clk.
  - Each transfer increments out_cnt. The transfer with out_cnt==len-1 moves to IDLE, pulses done=1 for one cycle and clears rd_valid.
- adc_valid outside CAPTURE: ignored, nothing written.
- abort=1: next state IDLE, rd_valid<=0, in_flight<=0, done stays 0. Any partial RAM contents are left as is. abort has priority over start and over every other transition in the same cycle.
- cap_len is sampled only when start is accepted; later changes have no effect.
- cap_len=DEPTH: wr_addr wraps from DEPTH-1 to 0 on the final write, which is harmless. rd_addr reaches DEPTH, so it uses ADDR_W+1 bits and ram_ad takes its low ADDR_W bits.
- busy goes to 1 the cycle after start is accepted and to 0 in the same cycle done=1.

Test Plan:
- Reset then start, cap_len=4, adc_data 0x001,0x002,0x003,0x004 on consecutive adc_valid, rd_ready=1:
  - Writes go to ad 0..3.
  - rd_data sequence is 0x001..0x004, one every 2 clk.
  - done pulses once and busy falls in the same cycle.
- Capture with gaps, cap_len=3, adc_valid pattern 1,0,0,1,0,1 carrying 0x3FF,0x000,0x155 -> exactly 3 writes at ad 0,1,2, readback 0x3FF,0x000,0x155.
- Backpressure, cap_len=2, rd_ready=0 for 5 clk after rd_valid rises -> rd_data holds 0x(first) and no extra ram read is issued; after rd_ready=1 both samples arrive in order.
- Illegal lengths: start with cap_len=0, then with cap_len=8193 -> busy stays 0 and no ram_wre.
- abort during CAPTURE after 2 of 5 samples, then abort during READ after 1 transfer -> IDLE next clk, rd_valid=0, done never pulses. A following start with cap_len=1 works normally.
- Full depth, cap_len=8192 with a ramp adc_data=addr[9:0] -> 8192 readback samples match the ramp, the last at ad 0x1FFF, done pulses once.

Source files
------------

// File: rtl/adc_capture_ctrl.sv
// Capture/readback controller for the single-port ADC sample RAM.
// Writes cap_len valid samples from address 0, then streams them out over valid/ready.
module adc_capture_ctrl #(
  parameter int DEPTH  = 8192,
  parameter int ADDR_W = 13,
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   cap_len,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              ram_ce,
  output logic              ram_oce,
  output logic              ram_wre,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_READ} state_t;

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_L   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [ADDR_W:0]     rd_addr_q, rd_addr_d;
  logic [ADDR_W:0]     out_cnt_q, out_cnt_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic                in_flight_q, in_flight_d;
  logic                rd_valid_q, rd_valid_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;

  logic len_ok, last_wr, issue, xfer, last_xfer;

  assign len_ok    = (cap_len != '0) && (cap_len <= DEPTH_C);
  assign last_wr   = adc_valid && ({1'b0, wr_addr_q} == (len_q - ONE_L));
  // One read outstanding at a time; a new read may go out in the same cycle the held sample leaves.
  assign issue     = (rd_addr_q < len_q) && !in_flight_q && (!rd_valid_q || rd_ready);
  assign xfer      = rd_valid_q && rd_ready;
  assign last_xfer = xfer && (out_cnt_q == (len_q - ONE_L));

  always_comb begin
    state_d     = state_q;
    wr_addr_d   = wr_addr_q;
    rd_addr_d   = rd_addr_q;
    out_cnt_d   = out_cnt_q;
    len_d       = len_q;
    in_flight_d = in_flight_q;
    rd_valid_d  = rd_valid_q;
    rd_data_d   = rd_data_q;
    done_d      = 1'b0;
    ram_ce      = 1'b0;
    ram_wre     = 1'b0;
    ram_ad      = wr_addr_q;
    ram_din     = adc_data;

    case (state_q)
      S_IDLE: begin
        if (start && len_ok) begin
          len_d     = cap_len;
          wr_addr_d = '0;
          state_d   = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        ram_ce  = 1'b1;
        ram_wre = adc_valid;
        if (adc_valid) wr_addr_d = wr_addr_q + ONE_A;
        if (last_wr) begin
          state_d     = S_READ;
          rd_addr_d   = '0;
          out_cnt_d   = '0;
          in_flight_d = 1'b0;
        end
      end
      S_READ: begin
        ram_ce      = 1'b1;
        ram_ad      = rd_addr_q[ADDR_W-1:0];
        in_flight_d = issue;
        if (issue) rd_addr_d = rd_addr_q + ONE_L;
        if (in_flight_q) begin
          rd_data_d  = ram_dout;
          rd_valid_d = 1'b1;
        end else if (xfer) begin
          rd_valid_d = 1'b0;
        end
        if (xfer) out_cnt_d = out_cnt_q + ONE_L;
        if (last_xfer) begin
          state_d    = S_IDLE;
          done_d     = 1'b1;
          rd_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d     = S_IDLE;
      rd_valid_d  = 1'b0;
      in_flight_d = 1'b0;
      done_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      out_cnt_q   <= '0;
      len_q       <= '0;
      in_flight_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      rd_addr_q   <= rd_addr_d;
      out_cnt_q   <= out_cnt_d;
      len_q       <= len_d;
      in_flight_q <= in_flight_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      done_q      <= done_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign ram_oce  = 1'b1;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Scoreboard bench for adc_capture_ctrl: stimulus queues expected RAM writes and
// readback samples; a negedge monitor pops and compares them as the DUT produces them.
module tb_adc_capture_ctrl;
  localparam int DEPTH = 8192, ADDR_W = 13, DATA_W = 10;

  logic clk = 1'b0, reset;
  logic start, abort, adc_valid, rd_ready;
  logic [ADDR_W:0] cap_len;
  logic [DATA_W-1:0] adc_data;
  logic busy, done, rd_valid, ram_ce, ram_oce, ram_wre;
  logic [DATA_W-1:0] rd_data, ram_din;
  logic [DATA_W-1:0] ram_dout = '0;
  logic [ADDR_W-1:0] ram_ad;

  always #5 clk = ~clk;

  adc_capture_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .cap_len(cap_len),
    .adc_data(adc_data), .adc_valid(adc_valid), .busy(busy), .done(done),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .ram_ce(ram_ce), .ram_oce(ram_oce), .ram_wre(ram_wre), .ram_ad(ram_ad),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Single-port RAM with one cycle read latency.
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_wre) mem[ram_ad] <= ram_din;
      ram_dout <= mem[ram_ad];
    end
  end

  typedef struct { int ad; int d; } wr_t;
  wr_t wr_q[$];
  int  rd_q[$];

  int total = 0, bad = 0;
  int cyc = 0, last_xfer_cyc = -1, last_epoch = 0, cap_epoch = 0;
  int xfer_cnt = 0, done_cnt = 0, exp_done = 0, rdy_mode = 0, wr_idx = 0;
  bit prev_stall = 1'b0, prev_done = 1'b0;
  int prev_data = 0;
  wr_t mw;
  int  me;

  task automatic check(input string nm, input int got, input int exp_v);
    total++;
    if (got !== exp_v) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", nm, got, exp_v, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT writes RAM or transfers a sample.
  always @(negedge clk) begin
    if (!reset) begin
      cyc++;
      if (ram_wre) begin
        check("wr_ce", ram_ce, 1);
        if (wr_q.size() == 0) check("wr_unexpected", ram_wre, 0);
        else begin
          mw = wr_q.pop_front();
          check("wr_ad", ram_ad, mw.ad);
          check("wr_din", ram_din, mw.d);
        end
      end
      if (prev_stall) begin
        check("hold_valid", rd_valid, 1);
        check("hold_data", rd_data, prev_data);
      end
      if (rd_valid && rd_ready) begin
        if (rd_q.size() == 0) check("rd_unexpected", rd_valid, 0);
        else begin
          me = rd_q.pop_front();
          check("rd_data", rd_data, me);
        end
        if (rdy_mode == 0 && last_xfer_cyc >= 0 && last_epoch == cap_epoch)
          check("rd_rate", cyc - last_xfer_cyc, 2);
        last_xfer_cyc = cyc;
        last_epoch    = cap_epoch;
        xfer_cnt++;
      end
      prev_stall = rd_valid && !rd_ready;
      prev_data  = rd_data;
      if (done) begin
        done_cnt++;
        check("done_busy", busy, 0);
        check("done_width", prev_done, 0);
        check("done_rdv", rd_valid, 0);
        check("done_drained", rd_q.size(), 0);
      end
      prev_done = done;
    end
  end

  task automatic idle_cycle();
    @(posedge clk); #1;
    abort     = 1'b0;
    start     = busy && ($urandom_range(0, 7) == 0);
    cap_len   = (ADDR_W+1)'($urandom);
    adc_valid = 1'($urandom);
    adc_data  = DATA_W'($urandom);
    if (rdy_mode == 1) rd_ready = ($urandom_range(0, 3) != 0);
    else if (rdy_mode == 0) rd_ready = 1'b1;
  endtask

  task automatic start_cap(input int len);
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b0; adc_valid = 1'b0;
    cap_len = (ADDR_W+1)'(len);
    wr_idx = 0;
    cap_epoch++;
    @(posedge clk); #1;
    start = 1'b0;
    cap_len = (ADDR_W+1)'($urandom);
    check("busy_rise", busy, 1);
  endtask

  task automatic drive_cycle(input bit v, input int d, input bit push_rd);
    wr_t w;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    adc_valid = v;
    adc_data  = DATA_W'(d);
    cap_len   = (ADDR_W+1)'($urandom);
    if (v) begin
      w.ad = wr_idx % DEPTH;
      w.d  = d & 1023;
      wr_q.push_back(w);
      wr_idx++;
      if (push_rd) rd_q.push_back(d & 1023);
    end
  endtask

  task automatic feed(input int n, input int gap_pct, input bit ramp, input int n_rd);
    int i = 0;
    while (i < n) begin
      if (int'($urandom_range(0, 99)) < gap_pct) drive_cycle(1'b0, int'($urandom_range(0, 1023)), 1'b0);
      else begin
        drive_cycle(1'b1, ramp ? i : int'($urandom_range(0, 1023)), i < n_rd);
        i++;
      end
    end
  endtask

  task automatic wait_done(input int budget);
    int target = done_cnt + 1;
    int n = 0;
    exp_done++;
    while (done_cnt < target && n < budget) begin
      idle_cycle();
      n++;
    end
    if (done_cnt < target) check("done_timeout", done_cnt, target);
    idle_cycle();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad_len [3];
    int n, x0, len;
    bad_len[0] = 0; bad_len[1] = 8193; bad_len[2] = 16383;
    start = 0; abort = 0; adc_valid = 1; adc_data = 10'h2AA; cap_len = 0; rd_ready = 1;
    reset = 1;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_ram_ce", ram_ce, 0);
    check("rst_ram_wre", ram_wre, 0);
    check("ram_oce", ram_oce, 1);

    // basic 4-sample capture, continuous consumer
    rdy_mode = 0;
    start_cap(4);
    for (int i = 1; i <= 4; i++) drive_cycle(1'b1, i, 1'b1);
    wait_done(200);

    // gaps in adc_valid
    start_cap(3);
    drive_cycle(1'b1, 10'h3FF, 1'b1);
    drive_cycle(1'b0, 10'h111, 1'b0);
    drive_cycle(1'b0, 10'h222, 1'b0);
    drive_cycle(1'b1, 10'h000, 1'b1);
    drive_cycle(1'b0, 10'h333, 1'b0);
    drive_cycle(1'b1, 10'h155, 1'b1);
    wait_done(200);

    // backpressure: hold the first sample for 5 clocks
    rdy_mode = 2; rd_ready = 0;
    start_cap(2);
    feed(2, 0, 1'b0, 2);
    n = 0;
    while (!rd_valid && n < 50) begin idle_cycle(); n++; end
    if (!rd_valid) check("bp_valid_timeout", rd_valid, 1);
    repeat (5) idle_cycle();
    check("bp_no_xfer", rd_q.size(), 2);
    rd_ready = 1;
    wait_done(200);

    // illegal lengths are ignored
    rdy_mode = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      start = 1; cap_len = (ADDR_W+1)'(bad_len[k]); adc_valid = 1;
      repeat (4) idle_cycle();
      check("illegal_busy", busy, 0);
    end

    // abort during capture after 2 of 5 samples
    start_cap(5);
    feed(2, 0, 1'b0, 0);
    @(posedge clk); #1; abort = 1; adc_valid = 0;
    @(posedge clk); #1; abort = 0; start = 0;
    check("abort_cap_busy", busy, 0);
    check("abort_cap_rdv", rd_valid, 0);
    repeat (10) idle_cycle();

    // abort during readback after one transfer
    start_cap(3);
    feed(3, 0, 1'b0, 1);
    x0 = xfer_cnt; n = 0;
    while (xfer_cnt == x0 && n < 50) begin idle_cycle(); n++; end
    check("abort_rd_first", xfer_cnt - x0, 1);
    abort = 1;
    @(posedge clk); #1; abort = 0; start = 0; adc_valid = 0;
    check("abort_rd_busy", busy, 0);
    check("abort_rd_rdv", rd_valid, 0);
    repeat (10) idle_cycle();
    check("abort_no_done", done_cnt, exp_done);

    start_cap(1);
    feed(1, 0, 1'b0, 1);
    wait_done(200);

    // full depth ramp with random consumer stalls
    rdy_mode = 1;
    start_cap(DEPTH);
    feed(DEPTH, 10, 1'b1, DEPTH);
    wait_done(60000);

    // a few random short captures
    for (int r = 0; r < 4; r++) begin
      rdy_mode = int'($urandom_range(0, 1));
      len = int'($urandom_range(1, 40));
      start_cap(len);
      feed(len, 30, 1'b0, len);
      wait_done(2000);
    end

    repeat (5) idle_cycle();
    check("wr_left", wr_q.size(), 0);
    check("rd_left", rd_q.size(), 0);
    check("done_count", done_cnt, exp_done);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
